fetcher: RTL and testbench

- Clocked instruction-fetch stage directly upstream of the issuer.
- Sequences the fetch PC and reads words from instruction memory over a req/ack interface.
- Buffers fetched words in a small FIFO and presents the head word to the issuer using a level-ready / toggle-trigger handshake.
- Branch redirects from later stages flush the buffer and restart fetch at the target.

---
 rtl/fetcher_if.sv | 25 ++
 rtl/fetcher.sv | 134 +++++++++++++
 tb/tb_fetcher.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetcher_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, branch redirect and issuer handshake.
// The master modport is the fetcher's view; slave is the memory/issuer/redirect side.
interface fetcher_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        branchValid;
    logic [31:0] branchTarget;
    logic        triggerIn;
    logic        readyOut;
    logic [31:0] dataOut;
    logic [31:0] pcOut;
    logic        protoErr;

    modport master (
        output imemReq, imemAddr, readyOut, dataOut, pcOut, protoErr,
        input  imemAck, imemData, branchValid, branchTarget, triggerIn
    );

    modport slave (
        input  imemReq, imemAddr, readyOut, dataOut, pcOut, protoErr,
        output imemAck, imemData, branchValid, branchTarget, triggerIn
    );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch stage: sequences the PC, fetches over req/ack into a prefetch FIFO,
// and presents the head word to the issuer with a level-ready / toggle-trigger handshake.
module fetcher #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      reset,
    fetcher_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    state_t        state, state_nxt;
    entry_t        mem [DEPTH];
    entry_t        head, head_nxt, push_entry;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt, count_left;
    logic [31:0]   fetch_pc, fetch_pc_nxt, req_addr;
    logic          req, ready, proto_err, trig_prev;
    logic          trig_edge, flush, pop, push, new_req, ready_nxt;

    // Handshake and FIFO bookkeeping; a redirect overrides everything else this cycle.
    always_comb begin
        trig_edge  = bus.triggerIn ^ trig_prev;
        flush      = bus.branchValid;
        pop        = trig_edge & ready & ~flush;
        push       = (state == REQ) & bus.imemAck & ~flush;
        push_entry = '{pc: fetch_pc, data: bus.imemData};
        count_left = count - CW'(pop);
        count_nxt  = flush ? '0 : count_left + CW'(push);
        head_nxt   = (count_left == '0) ? push_entry : mem[rd_ptr + PW'(pop)];
        // A pop always leaves one dead cycle so the issuer cannot resample a stale word.
        ready_nxt  = ~pop & ~flush & (count_nxt != '0);
    end

    // Fetch FSM next state; new_req marks the cycle a fresh address is launched.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        new_req      = 1'b0;
        case (state)
            IDLE: begin
                if (count < CW'(DEPTH)) begin
                    state_nxt = REQ;
                    new_req   = 1'b1;
                end
            end
            REQ: begin
                if (bus.imemAck) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    if (count_nxt < CW'(DEPTH)) begin
                        new_req = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (bus.imemAck) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            fetch_pc_nxt = bus.branchTarget;
            new_req      = 1'b0;
            state_nxt    = ((state != IDLE) && !bus.imemAck) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            req_addr  <= RESET_PC;
            req       <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ready     <= 1'b0;
            head      <= '0;
            proto_err <= 1'b0;
            trig_prev <= bus.triggerIn;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            req       <= (state_nxt != IDLE);
            trig_prev <= bus.triggerIn;
            count     <= count_nxt;
            ready     <= ready_nxt;
            if (new_req) begin
                req_addr <= fetch_pc_nxt;
            end
            if (trig_edge & ~ready & ~flush) begin
                proto_err <= 1'b1;
            end
            if (ready_nxt) begin
                head <= head_nxt;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign bus.imemReq  = req;
    assign bus.imemAddr = req_addr;
    assign bus.readyOut = ready;
    assign bus.dataOut  = head.data;
    assign bus.pcOut    = head.pc;
    assign bus.protoErr = proto_err;
endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed vector tables, multi-cycle corner sequences,
// and a randomized run scored against an expected fetch-address stream.
module tb_fetcher;
    localparam logic [31:0] PAT   = 32'hE000_0000;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        int          gap;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetcher_if bus0 ();
    fetcher_if bus1 ();

    int          lat0      = 0;
    bit          stall0    = 1'b0;
    int          cnt0      = 0;
    bit          force_ack = 1'b0;
    logic        mem_ack0  = 1'b0;
    logic [31:0] mem_data0 = '0;
    logic [31:0] ack_log [$];

    assign bus0.imemAck      = mem_ack0 | force_ack;
    assign bus0.imemData     = force_ack ? 32'hDEAD_BEEF : mem_data0;
    assign bus1.imemAck      = bus1.imemReq;
    assign bus1.imemData     = bus1.imemAddr ^ PAT;
    assign bus1.branchValid  = 1'b0;
    assign bus1.branchTarget = '0;

    fetcher #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    fetcher #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u1 (.clk(clk), .reset(reset), .bus(bus1));

    // Memory model: returns addr ^ PAT after lat0 waiting cycles, logs every acked address.
    always @(negedge clk) begin
        mem_ack0 = 1'b0;
        if (!bus0.imemReq || reset) begin
            cnt0 = 0;
        end else if (!stall0 && cnt0 >= lat0) begin
            mem_ack0  = 1'b1;
            mem_data0 = bus0.imemAddr ^ PAT;
            ack_log.push_back(bus0.imemAddr);
            cnt0 = 0;
        end else begin
            cnt0++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input bit dut1, input string name);
        int n = 0;
        while ((dut1 ? bus1.readyOut : bus0.readyOut) !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        check(name, 32'(dut1 ? bus1.readyOut : bus0.readyOut), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(bus0.imemReq),  32'd0);
        check({tag, "_addr"},  bus0.imemAddr,      32'h0);
        check({tag, "_ready"}, 32'(bus0.readyOut), 32'd0);
        check({tag, "_data"},  bus0.dataOut,       32'h0);
        check({tag, "_pc"},    bus0.pcOut,         32'h0);
        check({tag, "_perr"},  32'(bus0.protoErr), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        vec_t        vecs [6];
        vec_t        vecs1 [3];
        int          n;
        int          idx;
        int          pops;
        bit          pop_last;
        bit          br_last;
        bit          do_pop;
        bit          do_br;
        logic [31:0] exp_pc;
        logic [31:0] tgt;

        for (int i = 0; i < 6; i++) begin
            vecs[i] = '{gap: i % 3, exp_pc: 32'(4 * i), exp_data: 32'(4 * i) ^ PAT};
        end
        vecs1[0] = '{gap: 0, exp_pc: 32'hFFFF_FFF8, exp_data: 32'hFFFF_FFF8 ^ PAT};
        vecs1[1] = '{gap: 1, exp_pc: 32'hFFFF_FFFC, exp_data: 32'hFFFF_FFFC ^ PAT};
        vecs1[2] = '{gap: 2, exp_pc: 32'h0000_0000, exp_data: PAT};

        bus0.branchValid  = 1'b0;
        bus0.branchTarget = '0;
        bus0.triggerIn    = 1'b0;
        bus1.triggerIn    = 1'b0;

        // Reset values, then first request the cycle after deassert.
        reset = 1'b1;
        cyc(3);
        check_reset_outputs("rst");
        check("rst_addr1", bus1.imemAddr, 32'hFFFF_FFF8);
        reset = 1'b0;
        cyc(1);
        check("first_req",  32'(bus0.imemReq), 32'd1);
        check("first_addr", bus0.imemAddr,     32'h0);

        // Fill: first word presented, requests 0..12, then held idle while full.
        wait_ready(1'b0, "t1_ready");
        check("t1_pc",   bus0.pcOut,   32'h0);
        check("t1_data", bus0.dataOut, PAT);
        n = 0;
        while (bus0.imemReq && n < 50) begin
            cyc(1);
            n++;
        end
        check("t1_req_drop", 32'(bus0.imemReq), 32'd0);
        check("t1_log_size", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_log_addr", (i < ack_log.size()) ? ack_log[i] : 32'hFFFF_FFFF, 32'(4 * i));
        end
        cyc(3);
        check("t1_full_hold", 32'(bus0.imemReq), 32'd0);

        // Six pops, one dead ready cycle after each.
        for (int i = 0; i < 6; i++) begin
            wait_ready(1'b0, "t2_ready");
            check("t2_pc",   bus0.pcOut,   vecs[i].exp_pc);
            check("t2_data", bus0.dataOut, vecs[i].exp_data);
            cyc(vecs[i].gap);
            bus0.triggerIn = ~bus0.triggerIn;
            cyc(1);
            check("t2_gap",  32'(bus0.readyOut), 32'd0);
            cyc(1);
            check("t2_back", 32'(bus0.readyOut), 32'd1);
        end

        // Address wrap on the second instance.
        for (int i = 0; i < 3; i++) begin
            wait_ready(1'b1, "t4_ready");
            check("t4_pc",   bus1.pcOut,   vecs1[i].exp_pc);
            check("t4_data", bus1.dataOut, vecs1[i].exp_data);
            cyc(vecs1[i].gap);
            bus1.triggerIn = ~bus1.triggerIn;
            cyc(2);
        end

        // Redirect while the request to 8 is outstanding.
        lat0 = 3;
        do_reset();
        n = 0;
        while (!(bus0.imemReq === 1'b1 && bus0.imemAddr == 32'h8) && n < 100) begin
            cyc(1);
            n++;
        end
        check("t3_req8", bus0.imemAddr, 32'h8);
        idx = ack_log.size();
        bus0.branchValid  = 1'b1;
        bus0.branchTarget = 32'h100;
        cyc(1);
        bus0.branchValid = 1'b0;
        check("t3_flush_rdy",   32'(bus0.readyOut), 32'd0);
        check("t3_drain_req",   32'(bus0.imemReq),  32'd1);
        check("t3_drain_addr",  bus0.imemAddr,      32'h8);
        wait_ready(1'b0, "t3_ready");
        check("t3_pc",   bus0.pcOut,   32'h100);
        check("t3_data", bus0.dataOut, 32'h100 ^ PAT);
        check("t3_log_drain", (idx < ack_log.size()) ? ack_log[idx] : 32'hFFFF_FFFF, 32'h8);
        check("t3_log_next", (idx + 1 < ack_log.size()) ? ack_log[idx + 1] : 32'hFFFF_FFFF, 32'h100);

        // Trigger edge with an empty FIFO, then a trigger level held through reset.
        stall0 = 1'b1;
        lat0   = 0;
        do_reset();
        cyc(3);
        check("t5_empty", 32'(bus0.readyOut), 32'd0);
        bus0.triggerIn = ~bus0.triggerIn;
        cyc(1);
        check("t5_perr", 32'(bus0.protoErr), 32'd1);
        check("t5_rdy",  32'(bus0.readyOut), 32'd0);
        stall0 = 1'b0;
        wait_ready(1'b0, "t5_ready");
        check("t5_pc",   bus0.pcOut,   32'h0);
        check("t5_data", bus0.dataOut, PAT);
        check("t5_perr_sticky", 32'(bus0.protoErr), 32'd1);
        reset          = 1'b1;
        bus0.triggerIn = 1'b0;
        cyc(1);
        bus0.triggerIn = 1'b1;
        cyc(1);
        check("t5_perr_clr", 32'(bus0.protoErr), 32'd0);
        reset = 1'b0;
        wait_ready(1'b0, "t5_ready2");
        check("t5_pc2", bus0.pcOut, 32'h0);
        cyc(3);
        check("t5_nopop_rdy", 32'(bus0.readyOut), 32'd1);
        check("t5_nopop_pc",  bus0.pcOut,         32'h0);
        check("t5_nopop_perr", 32'(bus0.protoErr), 32'd0);

        // Reset during a pending request, then a stray ack right after reset.
        lat0 = 5;
        do_reset();
        cyc(2);
        check("t6_pending", 32'(bus0.imemReq), 32'd1);
        reset = 1'b1;
        cyc(1);
        check_reset_outputs("t6_rst");
        reset     = 1'b0;
        force_ack = 1'b1;
        cyc(1);
        force_ack = 1'b0;
        check("t6_restart_req",  32'(bus0.imemReq), 32'd1);
        check("t6_restart_addr", bus0.imemAddr,     32'h0);
        lat0 = 0;
        wait_ready(1'b0, "t6_ready");
        check("t6_pc",   bus0.pcOut,   32'h0);
        check("t6_data", bus0.dataOut, PAT);

        // Random traffic scored against the expected address stream.
        lat0 = 0;
        do_reset();
        exp_pc   = 32'h0;
        pops     = 0;
        pop_last = 1'b0;
        br_last  = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            cyc(1);
            bus0.branchValid = 1'b0;
            if (pop_last || br_last) begin
                check("rnd_gap", 32'(bus0.readyOut), 32'd0);
            end
            pop_last = 1'b0;
            br_last  = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                lat0 = $urandom_range(0, 3);
            end
            do_br  = ($urandom_range(0, 79) == 0);
            do_pop = (bus0.readyOut === 1'b1) && ($urandom_range(0, 1) == 1);
            if (do_pop) begin
                if (!do_br) begin
                    check("rnd_pc",   bus0.pcOut,   exp_pc);
                    check("rnd_data", bus0.dataOut, exp_pc ^ PAT);
                    exp_pc   = exp_pc + 32'd4;
                    pops++;
                    pop_last = 1'b1;
                end
                bus0.triggerIn = ~bus0.triggerIn;
            end
            if (do_br) begin
                tgt               = $urandom & 32'hFFFF_FFFC;
                bus0.branchValid  = 1'b1;
                bus0.branchTarget = tgt;
                exp_pc            = tgt;
                br_last           = 1'b1;
            end
        end
        cyc(1);
        bus0.branchValid = 1'b0;
        check("rnd_perr", 32'(bus0.protoErr), 32'd0);
        check("rnd_progress", 32'(pops >= 150), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
